extbus_sync: RTL and testbench
==============================

EXTBUS_SYNC -- requirements
Module: extbus_sync

Interface
REQ-001 The block SHALL have a parameter SYNC_STAGES, default 2, giving the flip-flop depth of the input synchronizer (legal 2..4).
REQ-002 The block SHALL have a parameter MIN_LOW, default 2, giving the minimum number of synchronized strobe-low cycles that make an access valid (legal 1..7).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Ports SHALL be:
- clk25  in  1  system clock, 25 MHz.
- reset_n  in  1  asynchronous active-low reset.
- extbus_cs_n  in  1  chip select, asynchronous.
- extbus_rd_n  in  1  read strobe, asynchronous.
- extbus_wr_n  in  1  write strobe, asynchronous.
- extbus_a  in  5  address, asynchronous.
- extbus_d_in  in  8  data from pad, asynchronous.
- extbus_d_out  out  8  data to pad.
- extbus_d_oe  out  1  pad output enable.
- bus_addr  out  5  captured access address.
- bus_wdata  out  8  captured write data.
- bus_wr  out  1  one-cycle write commit pulse.
- bus_rd_start  out  1  one-cycle pulse, read begins; bus_addr valid.
- bus_rd_end  out  1  one-cycle pulse, read completes (for post-read side effects such as auto-increment).
- bus_rdata  in  8  register read data, valid the cycle after bus_rd_start.
- glitch_cnt  out  8  saturating count of rejected strobe pulses.
- collision  out  1  sticky flag, rd and wr asserted together.
- status_clr  in  1  clears glitch_cnt and collision.

Function
REQ-005 cs_n, rd_n, wr_n, a and d_in SHALL each pass through a SYNC_STAGES flip-flop chain; all decisions SHALL use only synchronized values.
REQ-006 Effective strobes SHALL be rd = !cs_s & !rd_s and wr = !cs_s & !wr_s.
REQ-007 The FSM SHALL have states IDLE, WR_ACT, RD_ACT, COLLIDE; reset state IDLE.
REQ-008 IDLE SHALL go to WR_ACT when wr & !rd, to RD_ACT when rd & !wr, and to COLLIDE when rd & wr; a low-cycle counter SHALL be cleared on entry.
REQ-009 In WR_ACT, bus_addr and bus_wdata SHALL be loaded from the synchronized a and d every cycle while wr holds; values therefore reflect the last low cycle.
REQ-010 On WR_ACT exit (wr deasserted), bus_wr SHALL pulse for exactly one cycle if the low count reached MIN_LOW; otherwise there is no pulse, glitch_cnt increments, and the FSM returns to IDLE.
REQ-011 In RD_ACT, once the low count reaches MIN_LOW, bus_addr SHALL hold the synchronized a and bus_rd_start SHALL pulse once.
REQ-012 extbus_d_out SHALL load bus_rdata on the cycle after bus_rd_start and hold it until the read ends.
REQ-013 extbus_d_oe SHALL be 1 from the cycle after bus_rd_start until RD_ACT exit, and 0 otherwise.
REQ-014 On RD_ACT exit, bus_rd_end SHALL pulse once if bus_rd_start fired; otherwise glitch_cnt increments and there is no pulse.
REQ-015 If the other strobe asserts while in WR_ACT or RD_ACT, the FSM SHALL go to COLLIDE, set collision, and suppress all pending pulses (no bus_wr, no bus_rd_end).
REQ-016 extbus_d_oe SHALL be 0 in COLLIDE, and the FSM SHALL return to IDLE only when both rd and wr are deasserted.
REQ-017 The low counter SHALL saturate at 7, and glitch_cnt SHALL saturate at 255.
REQ-018 status_clr SHALL take priority over a same-cycle increment or set, leaving glitch_cnt 0 and collision 0.
REQ-019 bus_wr, bus_rd_start and bus_rd_end SHALL be mutually exclusive in any cycle.
REQ-020 Latency from a pad strobe edge to the resulting pulse SHALL be SYNC_STAGES+1 cycles.

Reset
REQ-021 Asserting reset_n low SHALL immediately force: FSM IDLE, all synchronizer flops to idle level (strobes 1, a/d 0), bus_addr 0, bus_wdata 0, extbus_d_out 0, extbus_d_oe 0, all pulses 0, glitch_cnt 0, collision 0.
REQ-022 Reset asserted mid-access SHALL abort the access without emitting any pulse.
REQ-023 After reset release, a strobe already held low SHALL be treated as a fresh access.

Structure
REQ-024 The FSM state encoding and the MIN_LOW/SYNC_STAGES defaults SHALL live in the shared package extbus_pkg.
REQ-025 The synchronizer chain SHALL be a sub-module sync_ff, parameterized by width and depth, instantiated for the strobes and for the a/d bus.

Verification
REQ-026 Write a=0x03, d=0x5A, wr low 6 cycles -> exactly one bus_wr with bus_addr 0x03, bus_wdata 0x5A, 3 cycles after wr_n rises.
REQ-027 Read a=0x10, bus_rdata=0xC3, rd low 8 cycles -> bus_rd_start once; extbus_d_oe 1 and extbus_d_out 0xC3 from the next cycle; bus_rd_end once after rd_n rises; oe then 0.
REQ-028 wr_n pulse of 1 synchronized cycle -> no bus_wr, glitch_cnt=1; 300 such pulses -> glitch_cnt=255.
REQ-029 rd low, then wr low 2 cycles later -> collision=1, no bus_rd_end, oe 0; FSM returns to IDLE after both strobes high; status_clr -> collision=0.
REQ-030 Strobe with cs_n=1 -> no pulses, no counter change; reset_n pulsed mid-write -> no bus_wr, all outputs 0.

Source files
------------

// File: rtl/extbus_pkg.sv
// Shared definitions for the external bus synchronizer: FSM encoding,
// parameter defaults and saturation limits.
package extbus_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWrAct   = 2'd1,
    StRdAct   = 2'd2,
    StCollide = 2'd3
  } state_e;

  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned MIN_LOW_DEF     = 2;

  localparam logic [2:0] LowCntMax = 3'd7;
  localparam logic [7:0] GlitchMax = 8'hFF;

  function automatic logic [2:0] low_cnt_inc(input logic [2:0] cnt);
    return (cnt == LowCntMax) ? cnt : cnt + 3'd1;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flip-flop synchronizer for asynchronous inputs, with a
// configurable reset level per bit.
module sync_ff #(
  parameter int unsigned      WIDTH   = 1,
  parameter int unsigned      DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_stage[i] <= RST_VAL;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/extbus_sync.sv
// External asynchronous bus slave front end: synchronizes pad signals,
// qualifies strobes by minimum low time and emits one-cycle bus pulses.
module extbus_sync
  import extbus_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned MIN_LOW     = MIN_LOW_DEF
) (
  input  logic       clk25,
  input  logic       reset_n,
  input  logic       extbus_cs_n,
  input  logic       extbus_rd_n,
  input  logic       extbus_wr_n,
  input  logic [4:0] extbus_a,
  input  logic [7:0] extbus_d_in,
  output logic [7:0] extbus_d_out,
  output logic       extbus_d_oe,
  output logic [4:0] bus_addr,
  output logic [7:0] bus_wdata,
  output logic       bus_wr,
  output logic       bus_rd_start,
  output logic       bus_rd_end,
  input  logic [7:0] bus_rdata,
  output logic [7:0] glitch_cnt,
  output logic       collision,
  input  logic       status_clr
);

  localparam logic [2:0] MinLowCnt = 3'(MIN_LOW);

  logic [2:0]  w_strb_s;
  logic [12:0] w_bus_s;
  logic        w_rd;
  logic        w_wr;
  logic [4:0]  w_a_s;
  logic [7:0]  w_d_s;
  logic [2:0]  w_cnt_inc;
  logic        w_glitch_inc;
  logic        w_coll_set;

  state_e      r_state;
  logic [2:0]  r_low_cnt;
  logic        r_rd_started;
  logic        r_rd_fetch;
  logic [4:0]  r_bus_addr;
  logic [7:0]  r_bus_wdata;
  logic [7:0]  r_d_out;
  logic        r_oe;
  logic        r_bus_wr;
  logic        r_rd_start;
  logic        r_rd_end;
  logic [7:0]  r_glitch_cnt;
  logic        r_collision;

  sync_ff #(
    .WIDTH  (3),
    .DEPTH  (SYNC_STAGES),
    .RST_VAL(3'b111)
  ) u_sync_strb (
    .i_clk  (clk25),
    .i_rst_n(reset_n),
    .i_d    ({extbus_cs_n, extbus_rd_n, extbus_wr_n}),
    .o_q    (w_strb_s)
  );

  sync_ff #(
    .WIDTH  (13),
    .DEPTH  (SYNC_STAGES),
    .RST_VAL(13'h0)
  ) u_sync_bus (
    .i_clk  (clk25),
    .i_rst_n(reset_n),
    .i_d    ({extbus_a, extbus_d_in}),
    .o_q    (w_bus_s)
  );

  assign w_rd      = ~w_strb_s[2] & ~w_strb_s[1];
  assign w_wr      = ~w_strb_s[2] & ~w_strb_s[0];
  assign w_a_s     = w_bus_s[12:8];
  assign w_d_s     = w_bus_s[7:0];
  assign w_cnt_inc = low_cnt_inc(r_low_cnt);

  always_comb begin
    w_glitch_inc = 1'b0;
    w_coll_set   = 1'b0;
    unique case (r_state)
      StIdle:    w_coll_set = w_rd & w_wr;
      StWrAct: begin
        w_coll_set   = w_rd;
        w_glitch_inc = ~w_rd & ~w_wr & (r_low_cnt < MinLowCnt);
      end
      StRdAct: begin
        w_coll_set   = w_wr;
        w_glitch_inc = ~w_rd & ~w_wr & ~r_rd_started;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= StIdle;
      r_low_cnt    <= 3'd0;
      r_rd_started <= 1'b0;
      r_rd_fetch   <= 1'b0;
      r_bus_addr   <= 5'h0;
      r_bus_wdata  <= 8'h0;
      r_d_out      <= 8'h0;
      r_oe         <= 1'b0;
      r_bus_wr     <= 1'b0;
      r_rd_start   <= 1'b0;
      r_rd_end     <= 1'b0;
    end else begin
      r_bus_wr   <= 1'b0;
      r_rd_start <= 1'b0;
      r_rd_end   <= 1'b0;
      r_rd_fetch <= r_rd_start;
      unique case (r_state)
        StIdle: begin
          // The cycle that triggers entry is already the first low cycle.
          r_low_cnt <= 3'd1;
          if (w_rd && w_wr) begin
            r_state <= StCollide;
          end else if (w_wr) begin
            r_state     <= StWrAct;
            r_bus_addr  <= w_a_s;
            r_bus_wdata <= w_d_s;
          end else if (w_rd) begin
            r_state      <= StRdAct;
            r_rd_started <= 1'b0;
            if (MinLowCnt <= 3'd1) begin
              r_rd_start   <= 1'b1;
              r_rd_started <= 1'b1;
              r_bus_addr   <= w_a_s;
            end
          end
        end
        StWrAct: begin
          if (w_rd) begin
            r_state <= StCollide;
          end else if (w_wr) begin
            r_low_cnt   <= w_cnt_inc;
            r_bus_addr  <= w_a_s;
            r_bus_wdata <= w_d_s;
          end else begin
            r_bus_wr <= (r_low_cnt >= MinLowCnt);
            r_state  <= StIdle;
          end
        end
        StRdAct: begin
          if (w_wr) begin
            r_state <= StCollide;
            r_oe    <= 1'b0;
          end else if (w_rd) begin
            r_low_cnt <= w_cnt_inc;
            if (!r_rd_started && (w_cnt_inc >= MinLowCnt)) begin
              r_rd_start   <= 1'b1;
              r_rd_started <= 1'b1;
              r_bus_addr   <= w_a_s;
            end
            // Load on both the start cycle and the one after, so either read
            // data timing of the register file is captured.
            if (r_rd_start || r_rd_fetch) begin
              r_d_out <= bus_rdata;
              r_oe    <= 1'b1;
            end
          end else begin
            r_rd_end <= r_rd_started;
            r_oe     <= 1'b0;
            r_state  <= StIdle;
          end
        end
        StCollide: begin
          r_oe <= 1'b0;
          if (!w_rd && !w_wr) begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      r_glitch_cnt <= 8'h0;
      r_collision  <= 1'b0;
    end else if (status_clr) begin
      r_glitch_cnt <= 8'h0;
      r_collision  <= 1'b0;
    end else begin
      if (w_glitch_inc && (r_glitch_cnt != GlitchMax)) begin
        r_glitch_cnt <= r_glitch_cnt + 8'd1;
      end
      if (w_coll_set) begin
        r_collision <= 1'b1;
      end
    end
  end

  assign extbus_d_out = r_d_out;
  assign extbus_d_oe  = r_oe;
  assign bus_addr     = r_bus_addr;
  assign bus_wdata    = r_bus_wdata;
  assign bus_wr       = r_bus_wr;
  assign bus_rd_start = r_rd_start;
  assign bus_rd_end   = r_rd_end;
  assign glitch_cnt   = r_glitch_cnt;
  assign collision    = r_collision;

endmodule

// File: tb/tb_extbus_sync.sv
// Self-checking bench for extbus_sync: access-level model checked every
// cycle plus directed scenarios with hand-computed expectations.
module tb_extbus_sync;

  localparam int S  = 2;
  localparam int ML = 2;

  logic       clk25;
  logic       reset_n;
  logic       extbus_cs_n;
  logic       extbus_rd_n;
  logic       extbus_wr_n;
  logic [4:0] extbus_a;
  logic [7:0] extbus_d_in;
  logic [7:0] extbus_d_out;
  logic       extbus_d_oe;
  logic [4:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_wr;
  logic       bus_rd_start;
  logic       bus_rd_end;
  logic [7:0] bus_rdata;
  logic [7:0] glitch_cnt;
  logic       collision;
  logic       status_clr;

  logic [7:0] mem [32];
  assign bus_rdata = mem[bus_addr];

  extbus_sync #(
    .SYNC_STAGES(S),
    .MIN_LOW    (ML)
  ) dut (
    .clk25       (clk25),
    .reset_n     (reset_n),
    .extbus_cs_n (extbus_cs_n),
    .extbus_rd_n (extbus_rd_n),
    .extbus_wr_n (extbus_wr_n),
    .extbus_a    (extbus_a),
    .extbus_d_in (extbus_d_in),
    .extbus_d_out(extbus_d_out),
    .extbus_d_oe (extbus_d_oe),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_wr      (bus_wr),
    .bus_rd_start(bus_rd_start),
    .bus_rd_end  (bus_rd_end),
    .bus_rdata   (bus_rdata),
    .glitch_cnt  (glitch_cnt),
    .collision   (collision),
    .status_clr  (status_clr)
  );

  initial begin
    clk25 = 1'b0;
    forever #20 clk25 = ~clk25;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk25) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- access-level model ----------------
  // Pads reach the decision logic S edges after being sampled.
  logic [15:0] h [S];
  int          m_kind;  // 0 none, 1 write, 2 read, 3 collision
  int          m_run;
  bit          m_started;
  logic        e_wr, e_rs, e_re, e_oe, e_coll;
  logic [4:0]  e_addr;
  logic [7:0]  e_wdata;
  int          e_glitch;

  always @(posedge clk25 or negedge reset_n) begin
    logic [15:0] u;
    bit          srd, swr, prev_rs, ginc, cset;
    if (!reset_n) begin
      for (int i = 0; i < S; i++) h[i] = 16'hE000;
      m_kind = 0; m_run = 0; m_started = 0;
      e_wr = 0; e_rs = 0; e_re = 0; e_oe = 0; e_coll = 0;
      e_addr = 0; e_wdata = 0; e_glitch = 0;
    end else begin
      u = h[S-1];
      for (int i = S - 1; i > 0; i--) h[i] = h[i-1];
      h[0] = {extbus_cs_n, extbus_rd_n, extbus_wr_n, extbus_a, extbus_d_in};
      srd = !u[15] && !u[14];
      swr = !u[15] && !u[13];
      prev_rs = e_rs;
      e_wr = 0; e_rs = 0; e_re = 0; ginc = 0; cset = 0;
      case (m_kind)
        0: begin
          if (srd && swr) begin
            m_kind = 3; cset = 1;
          end else if (swr) begin
            m_kind = 1; m_run = 1; e_addr = u[12:8]; e_wdata = u[7:0];
          end else if (srd) begin
            m_kind = 2; m_run = 1; m_started = 0;
            if (m_run >= ML) begin m_started = 1; e_rs = 1; e_addr = u[12:8]; end
          end
        end
        1: begin
          if (srd) begin
            m_kind = 3; cset = 1;
          end else if (swr) begin
            m_run++; e_addr = u[12:8]; e_wdata = u[7:0];
          end else begin
            if (m_run >= ML) e_wr = 1; else ginc = 1;
            m_kind = 0;
          end
        end
        2: begin
          if (swr) begin
            m_kind = 3; cset = 1; e_oe = 0;
          end else if (srd) begin
            m_run++;
            if (!m_started && m_run >= ML) begin
              m_started = 1; e_rs = 1; e_addr = u[12:8];
            end else if (prev_rs) begin
              e_oe = 1;
            end
          end else begin
            e_re = m_started; ginc = !m_started; e_oe = 0; m_kind = 0;
          end
        end
        default: if (!srd && !swr) m_kind = 0;
      endcase
      if (status_clr) begin
        e_glitch = 0; e_coll = 0;
      end else begin
        if (ginc && e_glitch < 255) e_glitch++;
        if (cset) e_coll = 1;
      end
    end
  end

  // ---------------- per-cycle compare + pulse tally ----------------
  int         n_wr, n_rs, n_re, wr_cyc, rs_cyc, re_cyc, oe_first;
  logic [4:0] wr_addr, rs_addr;
  logic [7:0] wr_data, dout_first;
  bit         oe_seen, oe_at_re, any_oe;

  always @(posedge clk25) begin
    #1;
    chk("bus_wr", 32'(bus_wr), 32'(e_wr));
    chk("bus_rd_start", 32'(bus_rd_start), 32'(e_rs));
    chk("bus_rd_end", 32'(bus_rd_end), 32'(e_re));
    chk("d_oe", 32'(extbus_d_oe), 32'(e_oe));
    chk("collision", 32'(collision), 32'(e_coll));
    chk("glitch_cnt", 32'(glitch_cnt), 32'(e_glitch));
    chk("bus_addr", 32'(bus_addr), 32'(e_addr));
    chk("bus_wdata", 32'(bus_wdata), 32'(e_wdata));
    if (e_oe) chk("d_out", 32'(extbus_d_out), 32'(mem[e_addr]));
    chk("pulse_excl", 32'($countones({bus_wr, bus_rd_start, bus_rd_end}) > 1), 32'(0));
    if (bus_wr) begin n_wr++; wr_cyc = cyc; wr_addr = bus_addr; wr_data = bus_wdata; end
    if (bus_rd_start) begin n_rs++; rs_cyc = cyc; rs_addr = bus_addr; end
    if (bus_rd_end) begin n_re++; re_cyc = cyc; oe_at_re = extbus_d_oe; end
    if (extbus_d_oe) begin
      any_oe = 1;
      if (!oe_seen) begin oe_seen = 1; oe_first = cyc; dout_first = extbus_d_out; end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk25);
  endtask

  task automatic clr_tally();
    n_wr = 0; n_rs = 0; n_re = 0; oe_seen = 0; any_oe = 0;
  endtask

  task automatic pads_idle();
    extbus_cs_n = 1; extbus_rd_n = 1; extbus_wr_n = 1;
  endtask

  task automatic glitch_wr();
    extbus_cs_n = 0; extbus_wr_n = 0;
    cycles(1);
    pads_idle();
    cycles(2);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_d_out"}, 32'(extbus_d_out), 0);
    chk({tag, "_d_oe"}, 32'(extbus_d_oe), 0);
    chk({tag, "_addr"}, 32'(bus_addr), 0);
    chk({tag, "_wdata"}, 32'(bus_wdata), 0);
    chk({tag, "_pulses"}, 32'({bus_wr, bus_rd_start, bus_rd_end}), 0);
    chk({tag, "_glitch"}, 32'(glitch_cnt), 0);
    chk({tag, "_coll"}, 32'(collision), 0);
  endtask

  int t_rise;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'(i * 37 + 11);
    mem[16] = 8'hC3;
    reset_n = 0; status_clr = 0; extbus_a = 0; extbus_d_in = 0;
    pads_idle();
    clr_tally();
    cycles(3);
    chk_all_zero("reset");
    reset_n = 1;
    cycles(3);

    // Write a=0x03 d=0x5A, 6 low cycles
    clr_tally();
    extbus_a = 5'h03; extbus_d_in = 8'h5A; extbus_cs_n = 0; extbus_wr_n = 0;
    cycles(6);
    pads_idle(); t_rise = cyc;
    cycles(6);
    chk("wr_count", 32'(n_wr), 1);
    chk("wr_latency", 32'(wr_cyc - t_rise), 3);
    chk("wr_addr", 32'(wr_addr), 32'h03);
    chk("wr_data", 32'(wr_data), 32'h5A);

    // Read a=0x10, 8 low cycles
    clr_tally();
    extbus_a = 5'h10; extbus_cs_n = 0; extbus_rd_n = 0;
    cycles(8);
    pads_idle(); t_rise = cyc;
    cycles(6);
    chk("rs_count", 32'(n_rs), 1);
    chk("rs_addr", 32'(rs_addr), 32'h10);
    chk("oe_after_rs", 32'(oe_first - rs_cyc), 1);
    chk("dout_first", 32'(dout_first), 32'hC3);
    chk("re_count", 32'(n_re), 1);
    chk("re_latency", 32'(re_cyc - t_rise), 3);
    chk("oe_at_re", 32'(oe_at_re), 0);

    // Glitch pulses and saturation
    clr_tally();
    glitch_wr();
    cycles(3);
    chk("glitch_one", 32'(glitch_cnt), 1);
    chk("glitch_no_wr", 32'(n_wr), 0);
    for (int i = 0; i < 299; i++) glitch_wr();
    cycles(3);
    chk("glitch_sat", 32'(glitch_cnt), 255);
    status_clr = 1; cycles(1); status_clr = 0; cycles(1);
    chk("glitch_clr", 32'(glitch_cnt), 0);
    glitch_wr(); cycles(3);
    chk("glitch_after_clr", 32'(glitch_cnt), 1);
    status_clr = 1; glitch_wr(); cycles(2); status_clr = 0; cycles(1);
    chk("clr_priority", 32'(glitch_cnt), 0);

    // Minimum-length write; data from the last low cycle
    clr_tally();
    extbus_a = 5'h07; extbus_d_in = 8'h11; extbus_cs_n = 0; extbus_wr_n = 0;
    cycles(1);
    extbus_d_in = 8'h99;
    cycles(1);
    pads_idle();
    cycles(6);
    chk("minlow_wr", 32'(n_wr), 1);
    chk("minlow_addr", 32'(wr_addr), 32'h07);
    chk("minlow_data", 32'(wr_data), 32'h99);
    chk("minlow_glitch", 32'(glitch_cnt), 0);

    // Read glitch
    clr_tally();
    extbus_cs_n = 0; extbus_rd_n = 0; cycles(1); pads_idle(); cycles(5);
    chk("rd_glitch_cnt", 32'(glitch_cnt), 1);
    chk("rd_glitch_pulses", 32'(n_rs + n_re), 0);

    // Collision: rd then wr two cycles later
    clr_tally();
    extbus_a = 5'h05; extbus_cs_n = 0; extbus_rd_n = 0;
    cycles(2);
    extbus_wr_n = 0;
    cycles(3);
    pads_idle();
    cycles(6);
    chk("coll_flag", 32'(collision), 1);
    chk("coll_no_re", 32'(n_re), 0);
    chk("coll_no_wr", 32'(n_wr), 0);
    chk("coll_no_oe", 32'(any_oe), 0);
    extbus_a = 5'h02; extbus_d_in = 8'h3C; extbus_cs_n = 0; extbus_wr_n = 0;
    cycles(3); pads_idle(); cycles(6);
    chk("coll_back_idle", 32'(n_wr), 1);
    status_clr = 1; cycles(1); status_clr = 0; cycles(1);
    chk("coll_clr", 32'(collision), 0);

    // Strobes without chip select
    clr_tally();
    glitch_wr(); cycles(3);
    extbus_cs_n = 1; extbus_wr_n = 0; cycles(6);
    extbus_wr_n = 1; extbus_rd_n = 0; cycles(6);
    extbus_wr_n = 0; cycles(4);
    pads_idle(); cycles(4);
    chk("nocs_pulses", 32'(n_wr + n_rs + n_re), 0);
    chk("nocs_glitch", 32'(glitch_cnt), 1);
    chk("nocs_coll", 32'(collision), 0);

    // Reset mid-write
    clr_tally();
    extbus_a = 5'h09; extbus_d_in = 8'h42; extbus_cs_n = 0; extbus_wr_n = 0;
    cycles(4);
    reset_n = 0;
    #1;
    chk_all_zero("midrst");
    pads_idle();
    cycles(2);
    reset_n = 1;
    cycles(6);
    chk("midrst_no_wr", 32'(n_wr), 0);

    // Strobe held low across reset release is a fresh access
    clr_tally();
    extbus_a = 5'h1F; extbus_d_in = 8'hE7; extbus_cs_n = 0; extbus_wr_n = 0;
    cycles(3);
    reset_n = 0; cycles(2); reset_n = 1;
    cycles(4);
    pads_idle();
    cycles(6);
    chk("fresh_wr", 32'(n_wr), 1);
    chk("fresh_addr", 32'(wr_addr), 32'h1F);
    chk("fresh_data", 32'(wr_data), 32'hE7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
